noc_vc_bridge: RTL and testbench

- Packet-atomic steering bridge: one input flit stream, fanned out to NUM_VC virtual-channel output ports.
- At each packet header, a round-robin arbiter picks a VC among those reporting VCready. The VC stays locked until the tail flit handshakes.
- Sits between a local injection port and a router's per-VC input buffers. Generalises the fixed two-channel bridge to N channels with fair allocation and error flagging.

---
 rtl/noc_vc_bridge_pkg.sv | 18 +
 rtl/noc_vc_bridge_if.sv | 30 +++
 rtl/noc_rr_arbiter.sv | 31 +++
 rtl/noc_vc_bridge.sv | 123 ++++++++++++
 tb/tb_noc_vc_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_bridge_pkg.sv
// Shared definitions for the NoC virtual-channel bridge and its arbiter.
package noc_vc_bridge_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_VC = 2;
  localparam int STATS_W    = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Round-robin successor of a VC index, wrapping from n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_vc_bridge_if.sv
// Flit stream bundle: one input stream plus NUM_VC per-VC output streams.
// slave is the bridge side, master is the injector/router side.
interface noc_vc_bridge_if
  import noc_vc_bridge_pkg::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int DATA_W = DEF_DATA_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_flit;
  logic                     in_is_header;
  logic                     in_is_tail;
  logic [NUM_VC-1:0]        out_valid;
  logic [NUM_VC-1:0]        out_ready;
  logic [NUM_VC*DATA_W-1:0] out_flit;
  logic [NUM_VC-1:0]        out_is_header;
  logic [NUM_VC-1:0]        out_is_tail;
  logic [NUM_VC-1:0]        out_vc_ready;

  modport slave (
    input  in_valid, in_flit, in_is_header, in_is_tail, out_ready, out_vc_ready,
    output in_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

  modport master (
    output in_valid, in_flit, in_is_header, in_is_tail, out_ready, out_vc_ready,
    input  in_ready, out_valid, out_flit, out_is_header, out_is_tail
  );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module noc_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid
);

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    int               w_idx;
    logic [IDX_W-1:0] w_sel;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_sel = IDX_W'(w_idx);
      if (i_req[w_sel]) begin
        o_gnt_idx   = w_sel;
        o_gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_vc_bridge.sv
// Packet-atomic bridge steering one flit stream onto NUM_VC virtual channels.
// Optional build macro NOC_BRIDGE_STATS_EN adds per-VC packet counters and an orphan counter.
//
// state  | meaning
// IDLE   | no VC locked; headers wait for a grant, stray non-header flits are dropped
// LOCKED | cur_vc owns the stream until the tail flit handshakes
module noc_vc_bridge
  import noc_vc_bridge_pkg::*;
#(
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int VC_IDX_W = $clog2(NUM_VC)
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  noc_vc_bridge_if.slave       bus,
  output logic [VC_IDX_W-1:0]  o_cur_vc,
  output logic                 o_busy,
  output logic                 o_err_orphan
`ifdef NOC_BRIDGE_STATS_EN
  ,
  output logic [NUM_VC*STATS_W-1:0] o_pkt_cnt,
  output logic [STATS_W-1:0]        o_orphan_cnt
`endif
);

  state_e                   r_state;
  logic [VC_IDX_W-1:0]      r_cur_vc;
  logic [VC_IDX_W-1:0]      r_rr_ptr;
  logic                     r_busy;
  logic [VC_IDX_W-1:0]      w_gnt_idx;
  logic                     w_gnt_valid;
  logic                     w_locked;
  logic                     w_orphan;
  logic                     w_in_ready;
  logic                     w_tail_hs;
  logic [NUM_VC-1:0]        w_sel;
  logic [NUM_VC-1:0]        w_out_valid;
  logic [NUM_VC-1:0]        w_out_hdr;
  logic [NUM_VC-1:0]        w_out_tail;
  logic [NUM_VC*DATA_W-1:0] w_out_flit;

  noc_rr_arbiter #(.N(NUM_VC), .IDX_W(VC_IDX_W)) u_arb (
    .i_req       (bus.out_vc_ready),
    .i_ptr       (r_rr_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_locked = (r_state == ST_LOCKED);
  // Gated by reset so every output reads 0 while reset is held, even with a flit pending.
  assign w_orphan   = noc_rst_n & ~w_locked & bus.in_valid & ~bus.in_is_header;
  assign w_in_ready = w_locked ? bus.out_ready[r_cur_vc] : w_orphan;
  assign w_tail_hs  = w_locked & bus.in_valid & w_in_ready & bus.in_is_tail;

  // Zero-latency forwarding onto the locked VC; every other VC is held at 0.
  for (genvar g = 0; g < NUM_VC; g++) begin : g_fwd
    assign w_sel[g]                        = w_locked & (r_cur_vc == VC_IDX_W'(g));
    assign w_out_valid[g]                  = w_sel[g] & bus.in_valid;
    assign w_out_hdr[g]                    = w_sel[g] & bus.in_is_header;
    assign w_out_tail[g]                   = w_sel[g] & bus.in_is_tail;
    assign w_out_flit[g*DATA_W +: DATA_W]  = w_sel[g] ? bus.in_flit : '0;
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_is_header = w_out_hdr;
  assign bus.out_is_tail   = w_out_tail;
  assign bus.out_flit      = w_out_flit;
  assign o_cur_vc          = r_cur_vc;
  assign o_busy            = r_busy;
  assign o_err_orphan      = w_orphan;

  // Allocation FSM: grant a VC on a header in IDLE, release it on the tail handshake.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state  <= ST_IDLE;
      r_cur_vc <= '0;
      r_rr_ptr <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && bus.in_is_header && w_gnt_valid) begin
            r_cur_vc <= w_gnt_idx;
            r_state  <= ST_LOCKED;
            r_busy   <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_tail_hs) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= VC_IDX_W'(rr_next(int'(r_cur_vc), NUM_VC));
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef NOC_BRIDGE_STATS_EN
  logic [STATS_W-1:0] r_orphan_cnt;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_pkt_cnt
    logic [STATS_W-1:0] r_cnt;
    // Count completed packets per VC; wraps naturally at the counter width.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n)              r_cnt <= '0;
      else if (w_tail_hs && w_sel[g]) r_cnt <= r_cnt + STATS_W'(1);
    end
    assign o_pkt_cnt[g*STATS_W +: STATS_W] = r_cnt;
  end

  // Count discarded orphan flits.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n)    r_orphan_cnt <= '0;
    else if (w_orphan) r_orphan_cnt <= r_orphan_cnt + STATS_W'(1);
  end
  assign o_orphan_cnt = r_orphan_cnt;
`endif

endmodule

// File: tb/tb_noc_vc_bridge.sv
// Bench for noc_vc_bridge: a 2-VC and a 4-VC instance share one stimulus front end;
// t_sel4 picks which instance receives in_valid and which one the checks observe.
module tb_noc_vc_bridge;

  typedef struct {
    int          vc;
    logic [31:0] flit;
    bit          hdr;
    bit          tail;
  } exp_t;

  typedef struct {
    bit          dut4;
    logic [3:0]  vc_ready;
    logic [31:0] flit;
    bit          hdr;
    bit          tail;
    int          exp_vc;
    int          exp_wait;
  } vec_t;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        t_valid, t_hdr, t_tail, t_sel4;
  logic [31:0] t_flit;
  logic [3:0]  t_out_ready, t_vc_ready;

  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t m_e;

  noc_vc_bridge_if #(.NUM_VC(2), .DATA_W(32)) bus2 ();
  noc_vc_bridge_if #(.NUM_VC(4), .DATA_W(32)) bus4 ();

  logic       cur2, busy2, err2, busy4, err4;
  logic [1:0] cur4;
`ifdef NOC_BRIDGE_STATS_EN
  logic [31:0] pkt2;
  logic [15:0] orph2;
  logic [63:0] pkt4;
  logic [15:0] orph4;
`endif

  noc_vc_bridge #(.NUM_VC(2), .DATA_W(32)) u_dut2 (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .bus          (bus2),
    .o_cur_vc     (cur2),
    .o_busy       (busy2),
    .o_err_orphan (err2)
`ifdef NOC_BRIDGE_STATS_EN
    ,
    .o_pkt_cnt    (pkt2),
    .o_orphan_cnt (orph2)
`endif
  );

  noc_vc_bridge #(.NUM_VC(4), .DATA_W(32)) u_dut4 (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .bus          (bus4),
    .o_cur_vc     (cur4),
    .o_busy       (busy4),
    .o_err_orphan (err4)
`ifdef NOC_BRIDGE_STATS_EN
    ,
    .o_pkt_cnt    (pkt4),
    .o_orphan_cnt (orph4)
`endif
  );

  assign bus2.in_valid     = t_valid & ~t_sel4;
  assign bus2.in_flit      = t_flit;
  assign bus2.in_is_header = t_hdr;
  assign bus2.in_is_tail   = t_tail;
  assign bus2.out_ready    = t_out_ready[1:0];
  assign bus2.out_vc_ready = t_vc_ready[1:0];
  assign bus4.in_valid     = t_valid & t_sel4;
  assign bus4.in_flit      = t_flit;
  assign bus4.in_is_header = t_hdr;
  assign bus4.in_is_tail   = t_tail;
  assign bus4.out_ready    = t_out_ready;
  assign bus4.out_vc_ready = t_vc_ready;

  logic [3:0]   s_out_valid, s_out_hdr, s_out_tail;
  logic [127:0] s_out_flit;
  logic         s_in_ready, s_busy, s_err;
  logic [1:0]   s_cur_vc;

  assign s_out_valid = t_sel4 ? bus4.out_valid     : {2'b00, bus2.out_valid};
  assign s_out_hdr   = t_sel4 ? bus4.out_is_header : {2'b00, bus2.out_is_header};
  assign s_out_tail  = t_sel4 ? bus4.out_is_tail   : {2'b00, bus2.out_is_tail};
  assign s_out_flit  = t_sel4 ? bus4.out_flit      : {64'd0, bus2.out_flit};
  assign s_in_ready  = t_sel4 ? bus4.in_ready      : bus2.in_ready;
  assign s_busy      = t_sel4 ? busy4 : busy2;
  assign s_err       = t_sel4 ? err4  : err2;
  assign s_cur_vc    = t_sel4 ? cur4  : {1'b0, cur2};

  initial forever #5 noc_clk = ~noc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] f, input bit h, input bit t, input int vc, input bit push);
    t_valid = 1'b1;
    t_flit  = f;
    t_hdr   = h;
    t_tail  = t;
    if (push) sb_q.push_back('{vc, f, h, t});
  endtask

  // Waits for the input handshake, counting stall cycles; leaves time at posedge+1.
  task automatic wait_hs(output int waits);
    waits = 0;
    while (1) begin
      @(negedge noc_clk);
      if (s_in_ready) break;
      waits++;
      if (waits > 20) begin
        n_checks++;
        n_err++;
        $display("FAIL hs_timeout: no handshake after %0d cycles", waits);
        break;
      end
    end
    @(posedge noc_clk);
    #1;
  endtask

  // Scoreboard: every output handshake must match the oldest expected flit.
  always @(negedge noc_clk) begin
    chk("onehot_valid", ($countones(s_out_valid) <= 1), 1);
    for (int i = 0; i < 4; i++) begin
      if (s_out_valid[i] && t_out_ready[i]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: flit %0h on vc %0d, none expected", s_out_flit[i*32 +: 32], i);
        end else begin
          m_e = sb_q.pop_front();
          chk("sb_vc", i, m_e.vc);
          chk("sb_flit", s_out_flit[i*32 +: 32], m_e.flit);
          chk("sb_hdr", s_out_hdr[i], m_e.hdr);
          chk("sb_tail", s_out_tail[i], m_e.tail);
        end
      end
    end
  end

  vec_t vec [13];
  int   w;

  initial begin
    vec[0]  = '{0, 4'h3, 32'h11, 1, 1, 0, 1};
    vec[1]  = '{0, 4'h3, 32'h12, 1, 1, 1, 1};
    vec[2]  = '{0, 4'h3, 32'hA,  1, 0, 0, 1};
    vec[3]  = '{0, 4'h0, 32'hB,  0, 0, 0, 0};
    vec[4]  = '{0, 4'h0, 32'hC,  0, 1, 0, 0};
    vec[5]  = '{0, 4'h1, 32'h13, 1, 1, 0, 1};
    vec[6]  = '{1, 4'hF, 32'h41, 1, 1, 0, 1};
    vec[7]  = '{1, 4'hC, 32'h42, 1, 1, 2, 1};
    vec[8]  = '{1, 4'h2, 32'h43, 1, 0, 1, 1};
    vec[9]  = '{1, 4'h0, 32'h44, 0, 0, 1, 0};
    vec[10] = '{1, 4'h0, 32'h45, 0, 1, 1, 0};
    vec[11] = '{1, 4'hB, 32'h46, 1, 1, 3, 1};
    vec[12] = '{1, 4'h1, 32'h47, 1, 1, 0, 1};

    t_valid = 1'b1; t_hdr = 1'b0; t_tail = 1'b0; t_flit = 32'h5A5A;
    t_sel4 = 1'b0; t_out_ready = 4'hF; t_vc_ready = 4'h0;
    repeat (2) @(negedge noc_clk);
    for (int s = 0; s < 2; s++) begin
      t_sel4 = (s == 1);
      #1;
      chk("rst_busy", s_busy, 0);
      chk("rst_cur_vc", s_cur_vc, 0);
      chk("rst_out_valid", s_out_valid, 0);
      chk("rst_out_flit", |s_out_flit, 0);
      chk("rst_out_flags", {s_out_hdr, s_out_tail}, 0);
      chk("rst_in_ready", s_in_ready, 0);
      chk("rst_err", s_err, 0);
    end
    t_valid = 1'b0;
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;

    for (int k = 0; k < 13; k++) begin
      t_sel4     = vec[k].dut4;
      t_vc_ready = vec[k].vc_ready;
      drive(vec[k].flit, vec[k].hdr, vec[k].tail, vec[k].exp_vc, 1);
      wait_hs(w);
      chk($sformatf("vec%0d_wait", k), w, vec[k].exp_wait);
      if (vec[k].tail) t_valid = 1'b0;
    end

    // Header held with no VC ready, then VC2 becomes ready.
    t_sel4 = 1'b1;
    t_vc_ready = 4'h0;
    drive(32'h500, 1, 1, 2, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge noc_clk);
      chk("noready_in_ready", s_in_ready, 0);
      chk("noready_busy", s_busy, 0);
      @(posedge noc_clk);
      #1;
    end
    t_vc_ready = 4'h4;
    wait_hs(w);
    chk("noready_grant_wait", w, 1);
    t_valid = 1'b0;

    // Backpressure on the locked VC with its vc_ready dropped mid-packet.
    t_vc_ready = 4'h1;
    drive(32'hB0, 1, 0, 0, 1);
    wait_hs(w);
    chk("bp_hdr_wait", w, 1);
    t_out_ready = 4'hE;
    t_vc_ready  = 4'h0;
    drive(32'hB1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      chk("bp_in_ready", s_in_ready, 0);
      chk("bp_out_valid", s_out_valid, 4'h1);
      chk("bp_flit_held", s_out_flit[31:0], 32'hB1);
      chk("bp_busy", s_busy, 1);
      @(posedge noc_clk);
      #1;
    end
    t_out_ready = 4'hF;
    wait_hs(w);
    chk("bp_body_wait", w, 0);
    drive(32'hB2, 0, 1, 0, 1);
    wait_hs(w);
    chk("bp_tail_wait", w, 0);
    t_valid = 1'b0;

    // Orphan body flit in IDLE.
    drive(32'hDEAD, 0, 0, 0, 0);
    @(negedge noc_clk);
    chk("orphan_in_ready", s_in_ready, 1);
    chk("orphan_err", s_err, 1);
    chk("orphan_out_valid", s_out_valid, 0);
    chk("orphan_busy", s_busy, 0);
    @(posedge noc_clk);
    #1;
    t_valid = 1'b0;
    @(negedge noc_clk);
    chk("orphan_err_clear", s_err, 0);
    @(posedge noc_clk);
    #1;

    // Missing tail: a second header while locked is forwarded as data.
    t_vc_ready = 4'hF;
    drive(32'hD0, 1, 0, 1, 1);
    wait_hs(w);
    chk("dup_hdr0_wait", w, 1);
    drive(32'hD1, 1, 0, 1, 1);
    wait_hs(w);
    chk("dup_hdr1_wait", w, 0);
    drive(32'hD2, 0, 1, 1, 1);
    wait_hs(w);
    chk("dup_tail_wait", w, 0);
    t_valid = 1'b0;

    // Reset in the middle of a packet.
    drive(32'hE0, 1, 0, 2, 1);
    wait_hs(w);
    chk("mid_hdr_wait", w, 1);
    t_out_ready = 4'hB;
    drive(32'hE1, 0, 0, 2, 0);
    @(negedge noc_clk);
    chk("mid_busy", s_busy, 1);
    chk("mid_cur_vc", s_cur_vc, 2);
    chk("mid_out_valid", s_out_valid, 4'h4);
    #2;
    noc_rst_n = 1'b0;
    #1;
    chk("arst_busy", s_busy, 0);
    chk("arst_cur_vc", s_cur_vc, 0);
    chk("arst_out_valid", s_out_valid, 0);
    chk("arst_out_flit", |s_out_flit, 0);
    chk("arst_in_ready", s_in_ready, 0);
    chk("arst_err", s_err, 0);
    @(negedge noc_clk);
    t_valid = 1'b0;
    t_out_ready = 4'hF;
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
    drive(32'hF0, 1, 1, 0, 1);
    wait_hs(w);
    chk("post_rst4_wait", w, 1);
    t_valid = 1'b0;
    t_sel4 = 1'b0;
    drive(32'h21, 1, 1, 0, 1);
    wait_hs(w);
    chk("post_rst2_wait", w, 1);
    t_valid = 1'b0;
    repeat (2) @(negedge noc_clk);

`ifdef NOC_BRIDGE_STATS_EN
    chk("stats_pkt4_vc0", pkt4[15:0], 1);
    chk("stats_pkt4_rest", pkt4[63:16], 0);
    chk("stats_pkt2_vc0", pkt2[15:0], 1);
    chk("stats_orph4", orph4, 0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
